// File: rtl/riscv_core_pkg.sv
// Shared fetch-stage types: FSM state encoding and the {pc, instr} queue entry.
package riscv_core_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO with wrap-bit pointers and a combinational head read; used both as the
// request tag FIFO and as the instruction queue. flush_i empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic [31:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    output entry_t                 data_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    entry_t      mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        empty;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty && !flush_i;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fetch_instr_queue.sv
// Instruction fetch front end: issues word fetches, queues {pc, instr} for decode, flushes on redirect.
// FETCH_BYPASS_EN: when defined, a response hitting an empty queue is presented to decode in the same cycle.
module fetch_instr_queue
    import riscv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    localparam int unsigned   CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   DEPTH_LIM = DEPTH[CW:0];

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] tag_count;
    logic [CW-1:0] q_count;
    logic [31:0]   tag_pc;
    fetch_entry_t  q_head;
    fetch_entry_t  q_wdata;
    logic          q_empty;
    logic          req_fire;
    logic          rsp_accept;
    logic          bypass;
    logic          consume;
    logic [CW-1:0] pending;
    logic [CW-1:0] redirect_discard;

    // The tag FIFO occupancy is exactly the number of outstanding requests.
    assign imem_req_valid_o = (state_q == S_FETCH) &&
                              (({1'b0, q_count} + {1'b0, tag_count}) < DEPTH_LIM);
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_accept       = imem_rsp_valid_i && (state_q == S_FETCH) && !redirect_i;
    assign q_empty          = (q_count == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_accept && q_empty && !stall_i;
`else
    assign bypass = 1'b0;
`endif

    assign q_wdata = '{pc: tag_pc, instr: imem_rsp_data_i};
    assign consume = valid_o && !stall_i && !redirect_i;

    fetch_fifo #(.DEPTH(DEPTH), .entry_t(logic [31:0])) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (req_fire),
        .data_i  (fetch_pc_q),
        .pop_i   (rsp_accept),
        .data_o  (tag_pc),
        .count_o (tag_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_instr_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (rsp_accept && !bypass),
        .data_i  (q_wdata),
        .pop_i   (consume && !bypass),
        .data_o  (q_head),
        .count_o (q_count)
    );

    always_comb begin
        valid_o = 1'b0;
        pc_o    = '0;
        instr_o = '0;
        if (bypass) begin
            valid_o = 1'b1;
            pc_o    = tag_pc;
            instr_o = imem_rsp_data_i;
        end else if (!q_empty) begin
            valid_o = 1'b1;
            pc_o    = q_head.pc;
            instr_o = q_head.instr;
        end
    end

    // Responses still owed after a redirect: everything in flight plus this cycle's
    // request, minus a response that lands in the redirect cycle itself.
    always_comb begin
        pending          = (state_q == S_FLUSH) ? discard_q : tag_count;
        redirect_discard = pending + {{(CW-1){1'b0}}, req_fire};
        if (imem_rsp_valid_i && (redirect_discard != '0)) begin
            redirect_discard = redirect_discard - CNT_ONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (req_fire) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                end
            end
            S_FLUSH: begin
                if (imem_rsp_valid_i && (discard_q != '0)) begin
                    discard_d = discard_q - CNT_ONE;
                    if (discard_q == CNT_ONE) begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            discard_d  = redirect_discard;
            state_d    = (redirect_discard != '0) ? S_FLUSH : S_FETCH;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Scoreboard bench for fetch_instr_queue: an in-order memory model with adjustable latency
// feeds responses; fired requests push expected {pc, instr}, a monitor pops on each consume.
`timescale 1ns/1ps
module tb_fetch_instr_queue;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 4;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_instr_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .stall_i          (stall),
        .imem_req_valid_o (req_valid),
        .imem_req_addr_o  (req_addr),
        .imem_req_ready_i (req_ready),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .valid_o          (out_valid),
        .pc_o             (out_pc),
        .instr_o          (out_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          consumed = 0;
    int          first_fire_cyc = -1;
    int          first_valid_cyc = -1;
    logic [31:0] first_valid_pc = '0;
    logic [31:0] first_valid_instr = '0;
    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] fire_log[$];
    exp_t        e;
    pend_t       p;
    logic        prev_v = 1'b0, prev_s = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_pc = '0, prev_instr = '0;
    logic        fire;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0031_00B3;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] req);
        if (fire_log.size() > idx) check(name, fire_log[idx], req);
        else check(name, 32'hFFFF_FFFF, req);
    endtask

    // Memory model: one in-order response per cycle, due lat cycles after the request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                rsp_valid = 1'b1;
                rsp_data  = mem_data(p.addr);
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: consume-side scoreboard, stall-hold and occupancy checks, request logging.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
                continue;
            end
            fire = req_valid && req_ready;
            if (prev_v && prev_s && !prev_r) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_pc", out_pc, prev_pc);
                check("stall_hold_instr", out_instr, prev_instr);
            end
            if (out_valid && first_valid_cyc < 0) begin
                first_valid_cyc   = cyc;
                first_valid_pc    = out_pc;
                first_valid_instr = out_instr;
            end
            if (out_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc=%08h instr=%08h required no valid", out_pc, out_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("consume_pc", out_pc, e.pc);
                    check("consume_instr", out_instr, e.instr);
                    consumed++;
                    $display("consume pc=%08h instr=%08h", out_pc, out_instr);
                end
            end
            if (redirect) exp_q.delete();
            if (fire) begin
                fire_log.push_back(req_addr);
                if (first_fire_cyc < 0) first_fire_cyc = cyc;
                pend_q.push_back('{addr: req_addr, due: cyc + lat});
                if (!redirect) exp_q.push_back('{pc: req_addr, instr: mem_data(req_addr)});
            end
            if (exp_q.size() > DEPTH) begin
                checks++;
                errors++;
                $display("FAIL inflight_bound: got %0d required <= %0d", exp_q.size(), DEPTH);
            end
            prev_v = out_valid; prev_s = stall; prev_r = redirect;
            prev_pc = out_pc; prev_instr = out_instr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int a0, n0, n1, n2, n3, n4, waited;

    initial begin
        #2 rst = 1'b1;
        req_ready = 1'b1;
        probe();
        check("reset_req_valid", 32'(req_valid), 32'd0);
        check("reset_req_addr", req_addr, RESET_PC);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_pc", out_pc, 32'd0);
        check("reset_instr", out_instr, 32'd0);
        tick(1);
        rst = 1'b0;

        // Free-running fetch with 1-cycle memory.
        tick(8);
        check_log("first_req_addr", 0, 32'h8000_0000);
        check_log("second_req_addr", 1, 32'h8000_0004);
        check("first_valid_pc", first_valid_pc, 32'h8000_0000);
        check("first_valid_instr", first_valid_instr, 32'h0031_00B3);
        check("first_valid_latency", 32'(first_valid_cyc - first_fire_cyc), 32'(FIRST_LAT));

        // Decode stalled for 10 cycles.
        stall = 1'b1;
        tick(10);
        probe();
        check("stall_inflight", 32'(exp_q.size()), 32'(DEPTH));
        check("stall_req_blocked", 32'(req_valid), 32'd0);
        tick(1);
        stall = 1'b0;
        tick(3);

        // Memory not ready for 3 cycles.
        req_ready = 1'b0;
        probe();
        a0 = req_addr;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) probe();
            check("backpressure_valid", 32'(req_valid), 32'd1);
            check("backpressure_addr", req_addr, a0);
            tick(1);
        end
        n0 = fire_log.size();
        req_ready = 1'b1;
        tick(3);
        check_log("post_backpressure_addr0", n0, a0);
        check_log("post_backpressure_addr1", n0 + 1, a0 + 32'd4);

        // Redirect with two requests outstanding (3-cycle memory).
        req_ready = 1'b0;
        tick(6);
        lat = 3;
        n1 = fire_log.size();
        req_ready = 1'b1;
        tick(2);
        req_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h8000_0100;
        probe();
        check("two_outstanding", 32'(fire_log.size() - n1), 32'd2);
        tick(1);
        redirect = 1'b0;
        req_ready = 1'b1;
        n2 = fire_log.size();
        for (int i = 0; i < 2; i++) begin
            probe();
            check("flush_no_request", 32'(req_valid), 32'd0);
            check("flush_no_valid", 32'(out_valid), 32'd0);
            tick(1);
        end
        for (int i = 0; i < 3; i++) begin
            probe();
            check("redirect_valid_low", 32'(out_valid), 32'd0);
            tick(1);
        end
        tick(3);
        check_log("redirect_target_addr", n2, 32'h8000_0100);

        // Second redirect arriving while already flushing.
        req_ready = 1'b0;
        tick(8);
        n1 = fire_log.size();
        req_ready = 1'b1;
        tick(2);
        req_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h8000_0300;
        tick(1);
        redirect_pc = 32'h8000_0400;
        n3 = fire_log.size();
        check("flush_redirect_setup", 32'(n3 - n1), 32'd2);
        tick(1);
        redirect = 1'b0;
        req_ready = 1'b1;
        tick(8);
        check_log("flush_redirect_addr", n3, 32'h8000_0400);

        // Redirect coincident with a response and a request handshake.
        lat = 1;
        tick(6);
        redirect = 1'b1;
        redirect_pc = 32'h8000_0200;
        probe();
        check("coincident_setup", 32'(req_valid && req_ready && rsp_valid), 32'd1);
        n4 = fire_log.size();
        tick(1);
        redirect = 1'b0;
        tick(6);
        check_log("coincident_redirect_addr", n4, 32'h8000_0200);

        // Drain everything still owed.
        req_ready = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            tick(1);
            waited++;
        end
        probe();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("consumed_some", 32'(consumed >= 10), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_instr_queue.md
FETCH_INSTR_QUEUE -- requirements
Module: fetch_instr_queue

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 4, instruction queue entries; power of two, 2..16.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 redirect_i  input  1  flush queue and restart fetch at redirect_pc_i.
REQ-006 redirect_pc_i  input  32  new fetch address, word aligned.
REQ-007 stall_i  input  1  decode cannot accept this cycle.
REQ-008 imem_req_valid_o  output  1  fetch request valid.
REQ-009 imem_req_addr_o  output  32  fetch address.
REQ-010 imem_req_ready_i  input  1  memory accepts request.
REQ-011 imem_rsp_valid_i  input  1  in-order response valid; one per accepted request.
REQ-012 imem_rsp_data_i  input  32  instruction word.
REQ-013 valid_o  output  1  pc_o/instr_o hold a live instruction for decode.
REQ-014 pc_o  output  32  PC of the presented instruction.
REQ-015 instr_o  output  32  presented instruction.

Function
REQ-016 Handshake: request fires on imem_req_valid_o && imem_req_ready_i; decode consumes on valid_o && !stall_i.
REQ-017 FSM states S_IDLE, S_FETCH, S_FLUSH; reset enters S_IDLE; S_IDLE -> S_FETCH unconditionally after one cycle.
REQ-018 S_FETCH: imem_req_valid_o = 1 when queue occupancy + outstanding < DEPTH; else 0.
REQ-019 Each fired request advances fetch PC by 4, wrapping modulo 2^32; outstanding increments.
REQ-020 Each response decrements outstanding and writes {PC, data} to queue tail; PC comes from a tag FIFO written at request time.
REQ-021 Queue pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
REQ-022 Without bypass, a response written in cycle N is visible on valid_o in cycle N+1.
REQ-023 imem_req_addr_o stays stable while imem_req_valid_o && !imem_req_ready_i.
REQ-024 redirect_i: queue emptied, valid_o = 0 next cycle, fetch PC = redirect_pc_i, discard count = outstanding including any request firing that cycle.
REQ-025 redirect_i: next state is S_FLUSH if discard count > 0, else S_FETCH.
REQ-026 S_FLUSH: no requests issued; each response is dropped and decrements discard count; at 0, go to S_FETCH.
REQ-027 A response arriving in the same cycle as redirect_i is dropped and counted.
REQ-028 redirect_i in S_FLUSH reloads fetch PC and keeps discarding.
REQ-029 redirect_i has priority over stall_i and over a simultaneous consume.
REQ-030 Simultaneous enqueue and dequeue on a full queue is legal; occupancy is unchanged.
REQ-031 stall_i holds valid_o, pc_o and instr_o stable.

Reset
REQ-032 Reset values: imem_req_valid_o = 0, imem_req_addr_o = RESET_PC, valid_o = 0, pc_o = 0, instr_o = 0, outstanding = 0, discard count = 0, pointers = 0, state S_IDLE.
REQ-033 Reset mid-operation abandons in-flight requests; the memory side is reset by the same rst_i.

Configuration
REQ-034 FETCH_BYPASS_EN defined: a response arriving with the queue empty, !stall_i and no redirect is presented on valid_o/pc_o/instr_o in the same cycle (zero latency) and is not enqueued.
REQ-035 FETCH_BYPASS_EN undefined: every response is enqueued first (REQ-022).

Structure
REQ-036 fetch_state_e and the fetch queue entry struct {pc, instr} are defined in riscv_core_pkg.
REQ-037 Queue storage with pointers lives in one sub-module, fetch_fifo, parameterised by DEPTH and entry type; it is instantiated twice (tag FIFO and instruction queue).

Verification
REQ-038 Reset release, imem_req_ready_i = 1, 1-cycle response latency -> first request at 0x8000_0000, then 0x8000_0004; valid_o asserts with pc_o = 0x8000_0000.
REQ-039 stall_i held 10 cycles, DEPTH = 4 -> at most 4 requests outstanding plus queued; pc_o/instr_o stable throughout; no overflow.
REQ-040 Two requests outstanding, redirect_i with redirect_pc_i = 0x8000_0100 -> S_FLUSH; two responses dropped; next request at 0x8000_0100; valid_o low until its response arrives.
REQ-041 redirect_i coincident with a response and a request handshake -> both counted as discards; neither reaches valid_o.
REQ-042 imem_req_ready_i low for 3 cycles -> imem_req_addr_o held constant; PC advances only on the handshake.
REQ-043 With FETCH_BYPASS_EN: empty queue, response 0x0031_00B3 -> valid_o = 1 and instr_o = 0x0031_00B3 in the same cycle. Without FETCH_BYPASS_EN: same stimulus -> valid_o = 1 and instr_o = 0x0031_00B3 one cycle later.
